cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cache_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Two-port physical-memory arbiter: shares one line-wide memory port between
// an I-cache (fills only) and a D-cache (fills and write-backs).
// One transaction at a time: IDLE -> SERVE_I/SERVE_D -> DONE -> IDLE.
// Ties are broken round-robin; the memory command is registered on the grant
// edge and held stable until the memory completes.
module cache_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    // I-cache side
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    // D-cache side
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    // Physical-memory side
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE_I = 2'd1;
    localparam logic [1:0] ST_SERVE_D = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_last_grant;

    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_address;
    logic [LINE_W-1:0] r_pmem_wdata;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_serve_end;
    logic              w_i_resp;
    logic              w_d_resp;

    // A D-cache request is either a fill or a write-back
    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

    // Next-state and grant decode; DONE ignores requests to absorb requester deassert latency
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_serve_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_i_req && w_d_req) begin
                    if (r_last_grant == GRANT_D) begin
                        w_grant_i = 1'b1;
                    end else begin
                        w_grant_d = 1'b1;
                    end
                end else if (w_i_req) begin
                    w_grant_i = 1'b1;
                end else if (w_d_req) begin
                    w_grant_d = 1'b1;
                end

                if (w_grant_i) begin
                    w_state_nxt = ST_SERVE_I;
                end else if (w_grant_d) begin
                    w_state_nxt = ST_SERVE_D;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                if (pmem_resp) begin
                    w_state_nxt = ST_DONE;
                    w_serve_end = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Round-robin history; reset to D so the I-cache wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GRANT_D;
        end else if (w_grant_i) begin
            r_last_grant <= GRANT_I;
        end else if (w_grant_d) begin
            r_last_grant <= GRANT_D;
        end
    end

    // Memory command capture on grant; held untouched for the whole SERVE state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= ADDR_W'(0);
            r_pmem_wdata   <= LINE_W'(0);
        end else if (w_grant_i) begin
            r_pmem_read    <= 1'b1;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= i_pmem_address;
            r_pmem_wdata   <= LINE_W'(0);
        end else if (w_grant_d) begin
            // Write-back takes precedence when the D-cache raises both commands
            r_pmem_read    <= d_pmem_read & ~d_pmem_write;
            r_pmem_write   <= d_pmem_write;
            r_pmem_address <= d_pmem_address;
            r_pmem_wdata   <= d_pmem_wdata;
        end else if (w_serve_end) begin
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

    // Completion is steered combinationally to the requester being served
    assign w_i_resp = (r_state == ST_SERVE_I) & pmem_resp;
    assign w_d_resp = (r_state == ST_SERVE_D) & pmem_resp;

    assign i_pmem_resp  = w_i_resp;
    assign d_pmem_resp  = w_d_resp;
    assign i_pmem_rdata = w_i_resp ? pmem_rdata : LINE_W'(0);
    assign d_pmem_rdata = w_d_resp ? pmem_rdata : LINE_W'(0);

endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter: directed scenarios followed by randomized
// traffic from two independent requesters against a behavioural memory.
// Requesters push expected commands into per-port queues; a negedge monitor
// checks grants, command payload/stability, responses and idle behaviour.
module tb_cache_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LINE_W  = 256;
    localparam int unsigned TIMEOUT = 400;

    typedef struct {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_rd;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int   n_cmp = 0;
    int   n_err = 0;
    req_t q_i[$];
    req_t q_d[$];

    // Memory model controls
    int   mem_lat   = -1;
    bit   mem_spur  = 1'b0;
    bit   mem_force = 1'b0;
    bit   mem_busy  = 1'b0;
    int   mem_cnt   = 0;

    // Monitor state
    int                m_phase    = 0;   // 0 idle, 1 serving, 2 done
    bit                m_req_seen = 1'b0;
    bit                m_last_d   = 1'b1;
    bit                m_prev_i   = 1'b0;
    bit                m_prev_d   = 1'b0;
    bit                m_src_d    = 1'b0;
    logic              m_cmd;
    logic              m_cap_rd;
    logic              m_cap_wr;
    logic [ADDR_W-1:0] m_cap_addr;
    logic [LINE_W-1:0] m_cap_wdata;
    req_t              m_exp;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_rd),
        .i_pmem_address (i_addr),
        .i_pmem_rdata   (i_rdata),
        .i_pmem_resp    (i_resp),
        .d_pmem_read    (d_rd),
        .d_pmem_write   (d_wr),
        .d_pmem_address (d_addr),
        .d_pmem_wdata   (d_wdata),
        .d_pmem_rdata   (d_rdata),
        .d_pmem_resp    (d_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        v = LINE_W'(0);
        for (int k = 0; k < int'(LINE_W / 32); k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    // I-cache requester: hold the fill request until its completion pulse
    task automatic do_i(input logic [ADDR_W-1:0] a);
        req_t e;
        bit   got;
        got = 1'b0;
        @(posedge clk); #1;
        e.rd = 1'b1; e.wr = 1'b0; e.addr = a; e.wdata = LINE_W'(0);
        q_i.push_back(e);
        i_rd = 1'b1; i_addr = a;
        for (int c = 0; c < int'(TIMEOUT); c++) begin
            @(negedge clk);
            if (i_resp === 1'b1) begin got = 1'b1; break; end
        end
        chk("i_resp_timeout", LINE_W'(got), LINE_W'(1));
        @(posedge clk); #1;
        i_rd = 1'b0; i_addr = ADDR_W'($urandom());
    endtask

    // D-cache requester; optionally scrambles its inputs once the command is out
    task automatic do_d(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [LINE_W-1:0] wd, input bit scramble);
        req_t e;
        bit   got;
        bit   scr;
        got = 1'b0; scr = 1'b0;
        @(posedge clk); #1;
        e.rd = rd & ~wr; e.wr = wr; e.addr = a; e.wdata = wd;
        q_d.push_back(e);
        d_rd = rd; d_wr = wr; d_addr = a; d_wdata = wd;
        for (int c = 0; c < int'(TIMEOUT); c++) begin
            @(negedge clk);
            if (d_resp === 1'b1) begin got = 1'b1; break; end
            if (scramble && !scr && (pmem_read || pmem_write)) begin
                d_addr = ~a; d_wdata = ~wd; scr = 1'b1;
            end
        end
        chk("d_resp_timeout", LINE_W'(got), LINE_W'(1));
        @(posedge clk); #1;
        d_rd = 1'b0; d_wr = 1'b0; d_addr = ADDR_W'($urandom());
    endtask

    // Behavioural memory: completes a command after mem_lat extra cycles (random if negative)
    initial begin : mem_model
        pmem_resp  = 1'b0;
        pmem_rdata = LINE_W'(0);
        forever begin
            @(posedge clk); #2;
            pmem_rdata = rand_line();
            pmem_resp  = mem_force;
            if (rst) begin
                mem_busy = 1'b0;
            end else if (pmem_read || pmem_write) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_cnt  = (mem_lat < 0) ? int'($urandom_range(0, 4)) : mem_lat;
                end
                if (mem_cnt == 0) begin
                    pmem_resp = 1'b1;
                    mem_busy  = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end else begin
                mem_busy = 1'b0;
                if (mem_spur && $urandom_range(0, 5) == 0) pmem_resp = 1'b1;
            end
        end
    end

    // Monitor: transaction-level expectations sampled mid-cycle
    initial begin : monitor
        forever begin
            @(negedge clk);
            m_cmd = pmem_read | pmem_write;
            if (rst) begin
                chk("rst_pmem_read",  LINE_W'(pmem_read),    LINE_W'(0));
                chk("rst_pmem_write", LINE_W'(pmem_write),   LINE_W'(0));
                chk("rst_pmem_addr",  LINE_W'(pmem_address), LINE_W'(0));
                chk("rst_pmem_wdata", pmem_wdata,            LINE_W'(0));
                chk("rst_resp",       LINE_W'({i_resp, d_resp}), LINE_W'(0));
                chk("rst_rdata",      i_rdata | d_rdata,     LINE_W'(0));
                m_phase = 0; m_req_seen = 1'b0; m_last_d = 1'b1;
            end else if (m_phase == 2) begin
                chk("done_cmd",  LINE_W'(m_cmd), LINE_W'(0));
                chk("done_resp", LINE_W'({i_resp, d_resp}), LINE_W'(0));
                m_phase = 0; m_req_seen = 1'b0;
            end else begin
                if (m_phase == 0) begin
                    chk("grant_latency", LINE_W'(m_cmd), LINE_W'(m_req_seen));
                    if (m_cmd) begin
                        m_src_d  = (m_prev_i && m_prev_d) ? !m_last_d : m_prev_d;
                        m_last_d = m_src_d;
                        if (m_src_d) begin
                            chk("d_queue_nonempty", LINE_W'(q_d.size() != 0), LINE_W'(1));
                            if (q_d.size() != 0) begin
                                m_exp = q_d[0];
                                chk("d_cmd_addr",  LINE_W'(pmem_address), LINE_W'(m_exp.addr));
                                chk("d_cmd_read",  LINE_W'(pmem_read),    LINE_W'(m_exp.rd));
                                chk("d_cmd_write", LINE_W'(pmem_write),   LINE_W'(m_exp.wr));
                                if (m_exp.wr) chk("d_cmd_wdata", pmem_wdata, m_exp.wdata);
                            end
                        end else begin
                            chk("i_queue_nonempty", LINE_W'(q_i.size() != 0), LINE_W'(1));
                            if (q_i.size() != 0) begin
                                m_exp = q_i[0];
                                chk("i_cmd_addr",  LINE_W'(pmem_address), LINE_W'(m_exp.addr));
                                chk("i_cmd_read",  LINE_W'(pmem_read),    LINE_W'(1));
                                chk("i_cmd_write", LINE_W'(pmem_write),   LINE_W'(0));
                            end
                        end
                        m_cap_rd = pmem_read; m_cap_wr = pmem_write;
                        m_cap_addr = pmem_address; m_cap_wdata = pmem_wdata;
                        m_phase = 1;
                    end else begin
                        chk("idle_resp",  LINE_W'({i_resp, d_resp}), LINE_W'(0));
                        chk("idle_rdata", i_rdata | d_rdata, LINE_W'(0));
                    end
                end
                if (m_phase == 1) begin
                    chk("stable_read",  LINE_W'(pmem_read),    LINE_W'(m_cap_rd));
                    chk("stable_write", LINE_W'(pmem_write),   LINE_W'(m_cap_wr));
                    chk("stable_addr",  LINE_W'(pmem_address), LINE_W'(m_cap_addr));
                    chk("stable_wdata", pmem_wdata,            m_cap_wdata);
                    if (pmem_resp) begin
                        if (m_src_d) begin
                            chk("d_resp",       LINE_W'(d_resp), LINE_W'(1));
                            chk("d_other_resp", LINE_W'(i_resp), LINE_W'(0));
                            chk("d_rdata",      d_rdata, pmem_rdata);
                            chk("d_other_data", i_rdata, LINE_W'(0));
                            if (q_d.size() != 0) void'(q_d.pop_front());
                        end else begin
                            chk("i_resp",       LINE_W'(i_resp), LINE_W'(1));
                            chk("i_other_resp", LINE_W'(d_resp), LINE_W'(0));
                            chk("i_rdata",      i_rdata, pmem_rdata);
                            chk("i_other_data", d_rdata, LINE_W'(0));
                            if (q_i.size() != 0) void'(q_i.pop_front());
                        end
                        m_phase = 2;
                    end else begin
                        chk("serve_no_resp", LINE_W'({i_resp, d_resp}), LINE_W'(0));
                    end
                end
                m_req_seen = (m_phase == 0) && (i_rd || d_rd || d_wr);
            end
            m_prev_i = i_rd;
            m_prev_d = d_rd | d_wr;
        end
    end

    // Stimulus
    initial begin : stim
        bit seen;
        rst = 1'b1;
        i_rd = 1'b0; i_addr = ADDR_W'(0);
        d_rd = 1'b0; d_wr = 1'b0; d_addr = ADDR_W'(0); d_wdata = LINE_W'(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Tie right after reset: I first, then D write; the next tie goes to I again
        fork
            do_i(32'h0000_0100);
            do_d(1'b0, 1'b1, 32'h0000_0200, rand_line(), 1'b0);
        join
        fork
            do_i(32'h0000_0140);
            do_d(1'b1, 1'b0, 32'h0000_0240, rand_line(), 1'b0);
        join

        // D read and write together: write only
        do_d(1'b1, 1'b1, 32'h0000_0300, rand_line(), 1'b0);

        // I-only fill with a fixed memory latency
        mem_lat = 5;
        do_i(32'h0000_1000);

        // D inputs change mid-service; the memory command must not
        mem_lat = 4;
        do_d(1'b0, 1'b1, 32'h0000_0400, rand_line(), 1'b1);

        // Spurious memory completion while idle
        repeat (3) @(posedge clk);
        #1 mem_force = 1'b1;
        @(posedge clk); #1 mem_force = 1'b0;
        repeat (2) @(posedge clk);

        // Reset during an I fill with a completion pending; fill is re-served afterwards
        mem_lat = 8;
        fork
            do_i(32'h0000_0500);
            begin
                seen = 1'b0;
                for (int c = 0; c < int'(TIMEOUT); c++) begin
                    @(negedge clk);
                    if (pmem_read === 1'b1) begin seen = 1'b1; break; end
                end
                chk("rst_test_cmd_seen", LINE_W'(seen), LINE_W'(1));
                repeat (2) @(posedge clk);
                #1 rst = 1'b1; mem_force = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0; mem_force = 1'b0;
            end
        join

        // Randomized traffic from both requesters with spurious completions enabled
        mem_lat  = -1;
        mem_spur = 1'b1;
        fork
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_i(ADDR_W'($urandom()) & ADDR_W'(32'hFFFF_FFE0));
            end
            for (int n = 0; n < 40; n++) begin
                int op;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                op = int'($urandom_range(0, 2));
                do_d(op != 1, op != 0, ADDR_W'($urandom()) & ADDR_W'(32'hFFFF_FFE0), rand_line(), 1'b0);
            end
        join
        mem_spur = 1'b0;
        repeat (5) @(posedge clk);

        chk("i_queue_drained", LINE_W'(q_i.size()), LINE_W'(0));
        chk("d_queue_drained", LINE_W'(q_d.size()), LINE_W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
